// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling queue with first-word-fall-through output.
// A taken-branch flush drops every queued entry so no wrong-path word reaches decode.
module if_id_buffer #(
    parameter int          DEPTH = 2,
    parameter int          XLEN  = 32,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pc4,
    input  logic [XLEN-1:0] if_inst,
    output logic            if_ready,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [XLEN-1:0] id_inst,
    input  logic            id_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    entry_t        head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign if_ready = (count < CW'(DEPTH));
    assign id_valid = (count != '0);
    assign push     = if_valid & if_ready;
    assign pop      = id_valid & id_ready;
    assign head     = mem[rd_ptr];

    assign id_pc   = id_valid ? head.pc   : '0;
    assign id_pc4  = id_valid ? head.pc4  : '0;
    assign id_inst = id_valid ? head.inst : XLEN'(NOP);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; a write that coincides with rst/flush is never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: if_pc, pc4: if_pc4, inst: if_inst};
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, fill, drain, streaming wrap, flush, mid-stream reset.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, id_ready;
    logic [31:0] if_pc, if_pc4, if_inst;
    logic        if_ready, id_valid;
    logic [31:0] id_pc, id_pc4, id_inst;

    int n_cmp = 0;
    int n_err = 0;

    if_id_buffer #(.DEPTH(2), .XLEN(32), .NOP(32'h00000013)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst),
        .if_ready(if_ready), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst),
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid = v;
        if_pc    = pc;
        if_pc4   = pc + 32'd4;
        if_inst  = inst;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // T1 reset
        step(); step();
        chk("t1_valid", 32'(id_valid), 32'd0);
        chk("t1_inst",  id_inst, 32'h00000013);
        chk("t1_pc",    id_pc, 32'h0);
        chk("t1_pc4",   id_pc4, 32'h0);
        chk("t1_ready", 32'(if_ready), 32'd1);

        // T2 fill with decode stalled
        rst = 1'b0;
        drive(1'b1, 32'h0, 32'h00500093);
        step();
        chk("t2_valid", 32'(id_valid), 32'd1);
        chk("t2_pc",    id_pc, 32'h0);
        chk("t2_pc4",   id_pc4, 32'h4);
        chk("t2_inst",  id_inst, 32'h00500093);
        chk("t2_ready1", 32'(if_ready), 32'd1);
        drive(1'b1, 32'h4, 32'h00A00113);
        step();
        chk("t2_full", 32'(if_ready), 32'd0);
        chk("t2_head", id_pc, 32'h0);
        drive(1'b1, 32'h8, 32'h00108193);
        step();
        chk("t2_noacc_head",  id_pc, 32'h0);
        chk("t2_noacc_ready", 32'(if_ready), 32'd0);

        // T3 drain one from full, then 0x8 enters behind 0x4
        id_ready = 1'b1;
        step();
        chk("t3_pc",    id_pc, 32'h4);
        chk("t3_inst",  id_inst, 32'h00A00113);
        chk("t3_ready", 32'(if_ready), 32'd1);
        id_ready = 1'b0;
        step();
        chk("t3_hold_pc", id_pc, 32'h4);
        chk("t3_full",    32'(if_ready), 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        id_ready = 1'b1;
        step();
        chk("t3_pc8",   id_pc, 32'h8);
        chk("t3_inst8", id_inst, 32'h00108193);
        step();
        chk("t3_empty",    32'(id_valid), 32'd0);
        chk("t3_empty_nop", id_inst, 32'h00000013);
        chk("t3_empty_pc",  id_pc, 32'h0);

        // T4 streaming, pointers wrap several times with count held at 1
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(4 * i), 32'h10000000 + 32'(i));
            step();
            chk($sformatf("t4_pc%0d", i),   id_pc, 32'(4 * i));
            chk($sformatf("t4_pc4_%0d", i), id_pc4, 32'(4 * i + 4));
            chk($sformatf("t4_inst%0d", i), id_inst, 32'h10000000 + 32'(i));
            chk($sformatf("t4_rdy%0d", i),  32'(if_ready), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t4_drained", 32'(id_valid), 32'd0);

        // T5 flush at full with a held fetch
        id_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h00500093); step();
        drive(1'b1, 32'h4, 32'h00A00113); step();
        chk("t5_full", 32'(if_ready), 32'd0);
        drive(1'b1, 32'h8, 32'h00108193);
        flush = 1'b1;
        step();
        chk("t5_valid", 32'(id_valid), 32'd0);
        chk("t5_ready", 32'(if_ready), 32'd1);
        chk("t5_nop",   id_inst, 32'h00000013);
        flush = 1'b0;
        drive(1'b1, 32'h40, 32'h00000033);
        step();
        chk("t5_pc40",   id_pc, 32'h40);
        chk("t5_inst40", id_inst, 32'h00000033);
        // flush wins over a simultaneous push and pop
        drive(1'b1, 32'h44, 32'h00000013);
        id_ready = 1'b1;
        flush = 1'b1;
        step();
        chk("t5_flush_pp", 32'(id_valid), 32'd0);
        flush = 1'b0;

        // T6 reset mid-stream
        drive(1'b1, 32'h80, 32'h00000001); step();
        drive(1'b1, 32'h84, 32'h00000002); step();
        chk("t6_pre_pc", id_pc, 32'h84);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t6_valid", 32'(id_valid), 32'd0);
        chk("t6_inst",  id_inst, 32'h00000013);
        chk("t6_pc",    id_pc, 32'h0);
        chk("t6_ready", 32'(if_ready), 32'd1);
        rst = 1'b0;
        drive(1'b1, 32'h0, 32'h00500093);
        step();
        chk("t6_pc0",   id_pc, 32'h0);
        chk("t6_inst0", id_inst, 32'h00500093);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t6_done", 32'(id_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
